load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit between the pipeline and the word-based data memory.
//  Turns a RISC-V load/store (funct3, byte address, store data) into word-aligned memory
//  accesses with byte enables, then sign/zero-extends load results.
//  A misaligned access that crosses a word boundary is split into two accesses, and the
//  pipeline is stalled for one extra cycle.
// PARAMETERS
//  ADDR_WIDTH     12  byte-address width of the data memory (wraps modulo 2**ADDR_WIDTH)
//  DATA_WIDTH     32  data width; only 32 is supported
//  MISALIGN_SPLIT 1   1 = split word-crossing accesses; 0 = flag misaligned_fault instead
// PORTS
//  clock            in   1           system clock; single clock domain
//  reset            in   1           synchronous reset, active high
//  req_valid        in   1           MEM stage holds a load/store this cycle
//  req_write        in   1           1 = store, 0 = load
//  req_funct3       in   3           LB/LH/LW/LBU/LHU or SB/SH/SW encoding
//  req_addr         in   32          byte address; bits above ADDR_WIDTH ignored
//  req_wdata        in   32          store data, right-aligned (rs2)
//  load_data        out  32          extended load result, valid when done & !req_write
//  done             out  1           access completes this cycle
//  stall            out  1           hold the pipeline; req_* must stay stable
//  misaligned_fault out  1           illegal funct3 or misaligned access with MISALIGN_SPLIT=0
//  mem_enable       out  1           memory enable
//  mem_write_enable out  1           memory write enable
//  mem_byte_enable  out  4           memory byte lanes
//  mem_address      out  ADDR_WIDTH  word-aligned byte address ([1:0]=0)
//  mem_write_data   out  32          lane-shifted store data
//  mem_read_data    in   32          asynchronous memory read word
// BEHAVIOUR
//  - Reset: state=IDLE, hold_q=0. While reset=1, all outputs are 0: mem_enable, done, stall, fault, load_data.
//  - Operand decode: off = req_addr[1:0]; size mask m = 4'b0001 (B), 4'b0011 (H), 4'b1111 (W).
//    Build 8-bit lane mask M = m<<off. Access is split when M[7:4] != 0.
//  - Illegal funct3 for loads: 011, 110, 111. Illegal funct3 for stores: funct3[2]=1 or 011.
//    Illegal ops: fault=1, done=1, mem_enable=0, and no state change.
//  - Aligned (no split) access, IDLE: purely combinational, so there is zero extra latency.
//    Drive mem_enable=1, mem_address={req_addr[AW-1:2],2'b00}, be=M[3:0], wdata=req_wdata<<(8*off).
//    Set done=1 and stall=0. Load result: raw=mem_read_data>>(8*off), then sign- or zero-extend
//    to the size from funct3.
//  - Split access with MISALIGN_SPLIT=1, FSM IDLE->SECOND->IDLE:
//    IDLE cycle: access the lower word with be=M[3:0] and wdata=req_wdata<<(8*off).
//    Set stall=1 and done=0. For loads, hold_q <= mem_read_data>>(8*off).
//    SECOND cycle: mem_address=lower+4, wrapping modulo 2**ADDR_WIDTH; be=M[7:4];
//    wdata=req_wdata>>(8*(4-off)). Set stall=0 and done=1.
//    Load raw = hold_q | (mem_read_data<<(8*(4-off))), then extend. Next state is IDLE.
//  - Split access with MISALIGN_SPLIT=0: fault=1, done=1, mem_enable=0, so memory is untouched.
//  - req_valid=0 in IDLE: all mem_* outputs are 0, done=0, stall=0.
//    req_valid is ignored while in SECOND, because the request is held by the stall.
//  - Reset in SECOND: state goes to IDLE on that edge and the second access is not issued.
//    The first half of a split store stays written; there is no rollback.
//  - load_data=0 whenever done=0 or req_write=1.
// TESTING
//  1. SW 0xDEADBEEF @0x010, then LW @0x010 -> be=1111, load_data=0xDEADBEEF, done in the same cycle, stall=0.
//  2. SB 0x80 @0x013 -> be=1000, wdata=0x80000000. LB @0x013 -> 0xFFFFFF80. LBU @0x013 -> 0x00000080.
//  3. SW 0x11223344 @0x022 -> cyc0: addr 0x020, be=1100, wdata=0x33440000, stall=1.
//     cyc1: addr 0x024, be=0011, wdata=0x00001122, done=1. Then LW @0x022 -> 0x11223344 after 2 cycles.
//  4. LH @0xFFF with mem[0xFFF]=0x34, mem[0x000]=0x92 -> second access at addr 0x000 (wrap);
//     load_data=0xFFFF9234.
//  5. MISALIGN_SPLIT=0, LW @0x021 -> fault=1, done=1, mem_enable=0. Also funct3=011 load -> fault=1.
//  6. Split SW @0x022 with reset=1 during SECOND -> no write to 0x024, state=IDLE, stall=0 on the next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RISC-V byte-addressed loads/stores into word accesses with
// byte enables, splitting word-crossing accesses into two cycles and extending load results.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int MISALIGN_SPLIT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  done,
   output logic                  stall,
   output logic                  misaligned_fault,
   output logic                  mem_enable,
   output logic                  mem_write_enable,
   output logic [3:0]            mem_byte_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   typedef enum logic {IDLE, SECOND} state_t;

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  hold_load;
   logic [1:0]            off;
   logic [3:0]            size_m;
   logic [7:0]            lane;
   logic                  split, illegal;
   logic [ADDR_WIDTH-1:0] base;
   logic [4:0]            sh_lo;
   logic [5:0]            sh_hi;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                    input logic [DATA_WIDTH-1:0] raw);
      case (f3[1:0])
         2'b00:   extend = f3[2] ? {{(DATA_WIDTH-8){1'b0}}, raw[7:0]}
                                 : {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
         2'b01:   extend = f3[2] ? {{(DATA_WIDTH-16){1'b0}}, raw[15:0]}
                                 : {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   size_m = 4'b0001;
         2'b01:   size_m = 4'b0011;
         default: size_m = 4'b1111;
      endcase
   end

   assign off   = req_addr[1:0];
   assign lane  = {4'b0000, size_m} << off;
   assign split = |lane[7:4];
   assign base  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
   assign sh_lo = {off, 3'b000};
   // Only meaningful in SECOND, where off is never 0.
   assign sh_hi = 6'd32 - {1'b0, off, 3'b000};

   assign illegal = req_write ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

   always_comb begin
      state_nx         = state;
      hold_load        = 1'b0;
      load_data        = '0;
      done             = 1'b0;
      stall            = 1'b0;
      misaligned_fault = 1'b0;
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_byte_enable  = 4'b0000;
      mem_address      = '0;
      mem_write_data   = '0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (illegal || (split && MISALIGN_SPLIT == 0)) begin
                     misaligned_fault = 1'b1;
                     done             = 1'b1;
                  end else begin
                     mem_enable       = 1'b1;
                     mem_write_enable = req_write;
                     mem_address      = base;
                     mem_byte_enable  = lane[3:0];
                     mem_write_data   = req_wdata << sh_lo;
                     if (split) begin
                        stall     = 1'b1;
                        hold_load = !req_write;
                        state_nx  = SECOND;
                     end else begin
                        done = 1'b1;
                        if (!req_write)
                           load_data = extend(req_funct3, mem_read_data >> sh_lo);
                     end
                  end
               end
            end
            SECOND: begin
               // Request is held stable by the stall, so req_valid is not consulted.
               mem_enable       = 1'b1;
               mem_write_enable = req_write;
               mem_address      = base + ADDR_WIDTH'(4);
               mem_byte_enable  = lane[7:4];
               mem_write_data   = req_wdata >> sh_hi;
               done             = 1'b1;
               if (!req_write)
                  load_data = extend(req_funct3, hold_q | (mem_read_data << sh_hi));
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         hold_q <= '0;
      end else begin
         state <= state_nx;
         if (hold_load)
            hold_q <= mem_read_data >> sh_lo;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level memory model predicts every output of a split-enabled
// and a split-disabled instance each cycle; literal values pin the model on the key vectors.
module tb_load_store_unit;
   localparam int AW = 12;

   typedef struct packed {
      logic          en;
      logic          we;
      logic [3:0]    be;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      logic          done;
      logic          stall;
      logic          fault;
      logic [31:0]   ld;
   } exp_t;

   logic          clock = 1'b1;
   logic          reset, req_valid, req_write;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;

   logic [31:0]   ld_s, wd_s, rd_s, ld_n, wd_n, rd_n;
   logic          done_s, stall_s, fault_s, en_s, we_s;
   logic          done_n, stall_n, fault_n, en_n, we_n;
   logic [3:0]    be_s, be_n;
   logic [AW-1:0] addr_s, addr_n;

   logic [7:0]    mem     [0:4095];
   logic [7:0]    ref_mem [0:4095];

   exp_t          exp_s, exp_n;
   bit            chk_en;
   int            total, bad;

   bit            pin_m_en, pin_ld_en, pin_n_en;
   logic [3:0]    pin_be;
   logic [AW-1:0] pin_addr;
   logic [31:0]   pin_wd, pin_ld;

   bit            lit_m_en [2];
   logic [3:0]    lit_be   [2];
   logic [AW-1:0] lit_addr [2];
   logic [31:0]   lit_wd   [2];
   bit            lit_ld_en, lit_n_en;
   logic [31:0]   lit_ld;

   always #5 clock = ~clock;

   load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MISALIGN_SPLIT(1)) dut_s (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .load_data(ld_s), .done(done_s), .stall(stall_s), .misaligned_fault(fault_s),
      .mem_enable(en_s), .mem_write_enable(we_s), .mem_byte_enable(be_s),
      .mem_address(addr_s), .mem_write_data(wd_s), .mem_read_data(rd_s));

   load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MISALIGN_SPLIT(0)) dut_n (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .load_data(ld_n), .done(done_n), .stall(stall_n), .misaligned_fault(fault_n),
      .mem_enable(en_n), .mem_write_enable(we_n), .mem_byte_enable(be_n),
      .mem_address(addr_n), .mem_write_data(wd_n), .mem_read_data(rd_n));

   // Only the split-enabled instance writes memory; both read it asynchronously.
   assign rd_s = {mem[addr_s + 3], mem[addr_s + 2], mem[addr_s + 1], mem[addr_s]};
   assign rd_n = {mem[addr_n + 3], mem[addr_n + 2], mem[addr_n + 1], mem[addr_n]};

   always @(posedge clock)
      if (en_s && we_s)
         for (int j = 0; j < 4; j++)
            if (be_s[j]) mem[addr_s + j] <= wd_s[8*j +: 8];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s @%0t got=%h want=%h", name, $time, act, want);
      end
   endfunction

   // Expected outputs of cycle k of an access, derived byte by byte from the address range.
   function automatic exp_t model(bit w, bit [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                  bit split_en, int k);
      exp_t        e;
      int          n, a12, off, last, idx;
      bit          legal, crosses;
      logic [31:0] raw;
      e       = '0;
      legal   = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      n       = 1 << f3[1:0];
      a12     = int'(a[AW-1:0]);
      off     = a12 % 4;
      crosses = (off + n) > 4;
      if (!legal || (crosses && !split_en)) begin
         e.fault = 1'b1;
         e.done  = 1'b1;
         return e;
      end
      last   = crosses ? 1 : 0;
      e.en   = 1'b1;
      e.we   = w;
      e.addr = AW'(((a12 & ~3) + 4*k) % 4096);
      for (int j = 0; j < 4; j++) begin
         idx = 4*k + j - off;
         if (idx >= 0 && idx < n) e.be[j] = 1'b1;
         if (idx >= 0 && idx < 4) e.wd[8*j +: 8] = wd[8*idx +: 8];
      end
      e.done  = (k == last);
      e.stall = (k < last);
      if (!w && k == last) begin
         raw = '0;
         for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[(a12 + i) % 4096];
         if (!f3[2] && raw[8*n-1])
            for (int b = 8*n; b < 32; b++) raw[b] = 1'b1;
         e.ld = raw;
      end
      return e;
   endfunction

   always @(negedge clock) begin
      if (chk_en) begin
         chk("s_en", en_s, exp_s.en);       chk("s_we", we_s, exp_s.we);
         chk("s_be", be_s, exp_s.be);       chk("s_addr", addr_s, exp_s.addr);
         chk("s_wdata", wd_s, exp_s.wd);    chk("s_done", done_s, exp_s.done);
         chk("s_stall", stall_s, exp_s.stall); chk("s_fault", fault_s, exp_s.fault);
         chk("s_load", ld_s, exp_s.ld);
         chk("n_en", en_n, exp_n.en);       chk("n_we", we_n, exp_n.we);
         chk("n_be", be_n, exp_n.be);       chk("n_addr", addr_n, exp_n.addr);
         chk("n_wdata", wd_n, exp_n.wd);    chk("n_done", done_n, exp_n.done);
         chk("n_stall", stall_n, exp_n.stall); chk("n_fault", fault_n, exp_n.fault);
         chk("n_load", ld_n, exp_n.ld);
         if (pin_m_en) begin
            chk("lit_be", be_s, pin_be);
            chk("lit_addr", addr_s, pin_addr);
            chk("lit_wdata", wd_s, pin_wd);
         end
         if (pin_ld_en) chk("lit_load", ld_s, pin_ld);
         if (pin_n_en) begin
            chk("lit_n_fault", fault_n, 1);
            chk("lit_n_done", done_n, 1);
            chk("lit_n_en", en_n, 0);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_lits();
      lit_m_en[0] = 0; lit_m_en[1] = 0; lit_ld_en = 0; lit_n_en = 0;
      pin_m_en = 0; pin_ld_en = 0; pin_n_en = 0;
   endtask

   task automatic idle_cycle();
      req_valid = 0;
      exp_s     = '0;
      exp_n     = '0;
      step();
   endtask

   task automatic commit_bytes(logic [31:0] a, logic [31:0] wd, int first, int count);
      for (int i = first; i < first + count; i++)
         ref_mem[(int'(a[AW-1:0]) + i) % 4096] = wd[8*i +: 8];
   endtask

   task automatic run_op(bit w, bit [2:0] f3, logic [31:0] a, logic [31:0] wd);
      exp_t e0;
      int   ncyc;
      e0   = model(w, f3, a, wd, 1, 0);
      ncyc = e0.stall ? 2 : 1;
      for (int k = 0; k < ncyc; k++) begin
         req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
         exp_s     = model(w, f3, a, wd, 1, k);
         exp_n     = model(w, f3, a, wd, 0, 0);
         pin_m_en  = lit_m_en[k]; pin_be = lit_be[k]; pin_addr = lit_addr[k]; pin_wd = lit_wd[k];
         pin_ld_en = lit_ld_en && (k == ncyc - 1); pin_ld = lit_ld;
         pin_n_en  = lit_n_en && (k == 0);
         step();
      end
      if (w && !e0.fault) commit_bytes(a, wd, 0, 1 << f3[1:0]);
      clear_lits();
      idle_cycle();
   endtask

   task automatic lit_cyc(int k, logic [3:0] be, logic [AW-1:0] ad, logic [31:0] wd);
      lit_m_en[k] = 1; lit_be[k] = be; lit_addr[k] = ad; lit_wd[k] = wd;
   endtask

   task automatic lit_load(logic [31:0] v);
      lit_ld_en = 1; lit_ld = v;
   endtask

   initial begin
      total = 0; bad = 0; chk_en = 0;
      clear_lits();
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      // Reset with a live request: every output must stay 0.
      reset = 1; req_valid = 1; req_write = 0; req_funct3 = 3'b010;
      req_addr = 32'h10; req_wdata = 32'h0;
      exp_s = '0; exp_n = '0; chk_en = 1;
      step(); step();
      reset = 0;
      idle_cycle();

      lit_cyc(0, 4'b1111, 12'h010, 32'hDEADBEEF);
      run_op(1, 3'b010, 32'h010, 32'hDEADBEEF);
      lit_load(32'hDEADBEEF);
      run_op(0, 3'b010, 32'h010, 32'h0);

      lit_cyc(0, 4'b1000, 12'h010, 32'h80000000);
      run_op(1, 3'b000, 32'h013, 32'h80);
      lit_load(32'hFFFFFF80);
      run_op(0, 3'b000, 32'h013, 32'h0);
      lit_load(32'h00000080);
      run_op(0, 3'b100, 32'h013, 32'h0);

      lit_cyc(0, 4'b1100, 12'h020, 32'h33440000);
      lit_cyc(1, 4'b0011, 12'h024, 32'h00001122);
      run_op(1, 3'b010, 32'h022, 32'h11223344);
      lit_load(32'h11223344);
      run_op(0, 3'b010, 32'h022, 32'h0);

      run_op(1, 3'b000, 32'hFFF, 32'h34);
      run_op(1, 3'b000, 32'h000, 32'h92);
      lit_cyc(1, 4'b0001, 12'h000, 32'h0);
      lit_m_en[1] = 0;
      lit_load(32'hFFFF9234);
      run_op(0, 3'b001, 32'hFFF, 32'h0);
      run_op(0, 3'b101, 32'hFFF, 32'h0);
      run_op(0, 3'b001, 32'hABCD_F7FF, 32'h0);

      lit_n_en = 1;
      run_op(0, 3'b010, 32'h021, 32'h0);
      lit_n_en = 1;
      run_op(0, 3'b011, 32'h010, 32'h0);
      run_op(0, 3'b110, 32'h010, 32'h0);
      run_op(1, 3'b100, 32'h010, 32'h12345678);
      run_op(1, 3'b011, 32'h010, 32'h12345678);

      run_op(1, 3'b001, 32'h03F, 32'hCAFE_BABE);
      run_op(0, 3'b001, 32'h03F, 32'h0);
      run_op(0, 3'b101, 32'h012, 32'h0);
      run_op(0, 3'b101, 32'h011, 32'h0);
      run_op(1, 3'b010, 32'h043, 32'h8765_4321);
      run_op(0, 3'b010, 32'h041, 32'h0);
      run_op(1, 3'b000, 32'h051, 32'hFFFF_FF7F);
      run_op(0, 3'b000, 32'h051, 32'h0);

      // Reset lands during SECOND of a split store: lower half stays written, upper half never issued.
      req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h022; req_wdata = 32'hAABBCCDD;
      exp_s = model(1, 3'b010, 32'h022, 32'hAABBCCDD, 1, 0);
      exp_n = model(1, 3'b010, 32'h022, 32'hAABBCCDD, 0, 0);
      step();
      reset = 1;
      exp_s = '0; exp_n = '0;
      step();
      commit_bytes(32'h022, 32'hAABBCCDD, 0, 2);
      reset = 0;
      idle_cycle();
      lit_load(32'hFFFFCCDD);
      run_op(0, 3'b001, 32'h022, 32'h0);
      lit_load(32'h00001122);
      run_op(0, 3'b001, 32'h024, 32'h0);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
